// File: rtl/lfsr_pkg.sv
// Shared definitions for the multi-channel LFSR pattern detector.
//   state_e     : run-control FSM encoding (IDLE / RUN / DONE)
//   PAT_DEFAULT : power-on pattern loaded into every channel
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [10:0] PAT_DEFAULT = 11'b11010101100;

endpackage

// File: rtl/pattern_channel.sv
// One detector channel: programmable pattern/mask, masked compare, registered
// match pulse, saturating hit counter and first-hit timestamp capture.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   clear_i           : start of a new run, wipes the per-run results
//   eval_i            : the current sample is to be compared
//   slice_i           : compared slice of the LFSR state
//   idx_i             : sample index of the current sample
//   cfg_we_i          : load cfg_pattern_i / cfg_mask_i
//   match_o           : one-cycle pulse, cycle after a hit
//   counter_o         : saturating hit count
//   saturated_o       : sticky, counter reached all-ones
//   first_seen_o      : sticky, channel hit at least once this run
//   first_ts_o        : sample index of the first hit
module pattern_channel
  import lfsr_pkg::*;
#(
  parameter int PAT_W = 11,
  parameter int CNT_W = 13,
  parameter int TS_W  = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             eval_i,
  input  logic [PAT_W-1:0] slice_i,
  input  logic [TS_W-1:0]  idx_i,
  input  logic             cfg_we_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [PAT_W-1:0] cfg_mask_i,
  output logic             match_o,
  output logic [CNT_W-1:0] counter_o,
  output logic             saturated_o,
  output logic             first_seen_o,
  output logic [TS_W-1:0]  first_ts_o
);

  localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEFAULT);

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             seen_q, seen_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             hit;

  always_comb begin
    pat_d   = pat_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    seen_d  = seen_q;
    ts_d    = ts_q;
    // Mask bit 0 = don't care, so an all-zero mask hits every evaluated sample.
    hit     = eval_i && (((slice_i ^ pat_q) & mask_q) == '0);
    match_d = hit;

    if (cfg_we_i) begin
      pat_d  = cfg_pattern_i;
      mask_d = cfg_mask_i;
    end

    // clear and hit are mutually exclusive: clear only outside RUN, hit only in RUN.
    if (clear_i) begin
      cnt_d  = '0;
      sat_d  = 1'b0;
      seen_d = 1'b0;
      ts_d   = '0;
    end else if (hit) begin
      cnt_d = cnt_sat_inc(cnt_q);
      if (&cnt_d) sat_d = 1'b1;
      if (!seen_q) begin
        seen_d = 1'b1;
        ts_d   = idx_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= PAT_RST;
      mask_q  <= '1;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      seen_q  <= 1'b0;
      ts_q    <= '0;
    end else begin
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      seen_q  <= seen_d;
      ts_q    <= ts_d;
    end
  end

  assign match_o      = match_q;
  assign counter_o    = cnt_q;
  assign saturated_o  = sat_q;
  assign first_seen_o = seen_q;
  assign first_ts_o   = ts_q;

endmodule

// File: rtl/multi_pattern_detector.sv
// Multi-channel pattern detector that sits beside an LFSR core. Frames a run
// with start/stop/loop, tracks the sample index, and fans the compared slice
// out to NUM_CH independent pattern channels.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   lfsr, lfsr_valid      : LFSR state and its sample strobe
//   loop                  : LFSR back at its seed (ends the run after evaluation)
//   start, stop           : run control pulses
//   cfg_we/cfg_ch/cfg_pattern/cfg_mask : channel programming (IDLE/DONE only)
//   busy, done            : FSM in RUN / in DONE
//   match, counter, saturated, first_seen, first_ts : per-channel results
module multi_pattern_detector
  import lfsr_pkg::*;
#(
  parameter int LFSR_W = 22,
  parameter int PAT_W  = 11,
  parameter int OFFSET = 11,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 13,
  parameter int TS_W   = 22,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LFSR_W-1:0]       lfsr,
  input  logic                    lfsr_valid,
  input  logic                    loop,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [PAT_W-1:0]        cfg_pattern,
  input  logic [PAT_W-1:0]        cfg_mask,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH-1:0]       match,
  output logic [NUM_CH*CNT_W-1:0] counter,
  output logic [NUM_CH-1:0]       saturated,
  output logic [NUM_CH-1:0]       first_seen,
  output logic [NUM_CH*TS_W-1:0]  first_ts
);

  function automatic logic [TS_W-1:0] idx_sat_inc(input logic [TS_W-1:0] v);
    return (&v) ? v : v + TS_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [TS_W-1:0]  idx_q, idx_d;
  logic             run_clear;
  logic             eval;
  logic             cfg_ok;
  logic [PAT_W-1:0] slice;
  logic             unused_lfsr_bits;

  assign slice            = lfsr[OFFSET +: PAT_W];
  assign unused_lfsr_bits = ^lfsr;

  // A start outside RUN both enters RUN and wipes the previous run's results.
  assign run_clear = start && (state_q != ST_RUN);
  // stop wins over the sample presented in the same cycle.
  assign eval      = (state_q == ST_RUN) && lfsr_valid && !stop;
  assign cfg_ok    = cfg_we && (state_q != ST_RUN);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (stop || (lfsr_valid && loop)) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    if (run_clear)  idx_d = '0;
    else if (eval)  idx_d = idx_sat_inc(idx_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    // Out-of-range cfg_ch values match no channel and are dropped.
    assign ch_we = cfg_ok && (cfg_ch == CH_W'(i));

    pattern_channel #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W),
      .TS_W  (TS_W)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .clear_i       (run_clear),
      .eval_i        (eval),
      .slice_i       (slice),
      .idx_i         (idx_q),
      .cfg_we_i      (ch_we),
      .cfg_pattern_i (cfg_pattern),
      .cfg_mask_i    (cfg_mask),
      .match_o       (match[i]),
      .counter_o     (counter[i*CNT_W +: CNT_W]),
      .saturated_o   (saturated[i]),
      .first_seen_o  (first_seen[i]),
      .first_ts_o    (first_ts[i*TS_W +: TS_W])
    );
  end

endmodule

// File: tb/tb_multi_pattern_detector.sv
module tb_multi_pattern_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [21:0] lfsr = '0;
  logic        lfsr_valid = 1'b0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_ch = '0;
  logic [10:0] cfg_pattern = '0;
  logic [10:0] cfg_mask = '0;

  logic        busy, done;
  logic [1:0]  match, saturated, first_seen;
  logic [25:0] counter;
  logic [43:0] first_ts;

  logic        busy4, done4;
  logic [1:0]  match4, saturated4, first_seen4;
  logic [7:0]  counter4;
  logic [43:0] first_ts4;

  int checks = 0;
  int errors = 0;

  localparam logic [10:0] PAT = 11'h6AC;

  always #5 clk = ~clk;

  multi_pattern_detector u_dut (
    .clk(clk), .reset(reset), .lfsr(lfsr), .lfsr_valid(lfsr_valid), .loop(loop),
    .start(start), .stop(stop), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .busy(busy), .done(done),
    .match(match), .counter(counter), .saturated(saturated),
    .first_seen(first_seen), .first_ts(first_ts)
  );

  multi_pattern_detector #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .lfsr(lfsr), .lfsr_valid(lfsr_valid), .loop(loop),
    .start(start), .stop(stop), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .busy(busy4), .done(done4),
    .match(match4), .counter(counter4), .saturated(saturated4),
    .first_seen(first_seen4), .first_ts(first_ts4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic v, input logic [10:0] s, input logic lp, input logic sp);
    lfsr       = {s, 11'h155};
    lfsr_valid = v;
    loop       = lp;
    stop       = sp;
    tick();
    lfsr_valid = 1'b0;
    loop       = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, match, saturated, first_seen} !== 8'h00 || counter !== '0 || first_ts !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b match=%b cnt=%h sat=%b seen=%b ts=%h, want all 0",
               busy, done, match, counter, saturated, first_seen, first_ts);
    end
    checks++;
    if (u_dut.g_ch[0].u_ch.pat_q !== 11'h6AC) begin
      errors++;
      $display("FAIL reset_pattern0: got %h want 6ac", u_dut.g_ch[0].u_ch.pat_q);
    end
    checks++;
    if (u_dut.g_ch[1].u_ch.mask_q !== 11'h7FF) begin
      errors++;
      $display("FAIL reset_mask1: got %h want 7ff", u_dut.g_ch[1].u_ch.mask_q);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_default_pattern();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    for (int k = 0; k < 3; k++) begin
      sample(1'b1, PAT, 1'b0, 1'b0);
      checks++;
      if (match !== 2'b11) begin errors++; $display("FAIL hit_match k=%0d: got %b want 11", k, match); end
    end
    sample(1'b1, 11'h6AD, 1'b0, 1'b0);
    checks++;
    if (match !== 2'b00) begin errors++; $display("FAIL miss_match: got %b want 00", match); end
    checks++;
    if (counter[12:0] !== 13'd3 || first_ts[21:0] !== 22'd0 || first_seen !== 2'b11) begin
      errors++;
      $display("FAIL default_results: cnt0=%0d ts0=%0d seen=%b want 3 0 11", counter[12:0], first_ts[21:0], first_seen);
    end
    sample(1'b0, PAT, 1'b0, 1'b1);
    checks++;
    if ({busy, done} !== 2'b01 || counter[12:0] !== 13'd3) begin
      errors++;
      $display("FAIL stop_done: busy=%b done=%b cnt0=%0d want 0 1 3", busy, done, counter[12:0]);
    end
  endtask

  task automatic test_mask_zero();
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_pattern = 11'h000; cfg_mask = 11'h000;
    tick();
    cfg_we = 1'b0;
    pulse_start();
    checks++;
    if (counter !== '0 || first_seen !== 2'b00) begin
      errors++;
      $display("FAIL start_clear: cnt=%h seen=%b want 0 00", counter, first_seen);
    end
    for (int k = 0; k < 15; k++) begin
      sample((k % 3) != 1, 11'(k + 1), 1'b0, 1'b0);
      if (k == 0 || k == 1) begin
        checks++;
        if (match !== {(k % 3) != 1, 1'b0}) begin
          errors++;
          $display("FAIL mask0_match k=%0d: got %b want %b", k, match, {(k % 3) != 1, 1'b0});
        end
      end
    end
    checks++;
    if (counter[25:13] !== 13'd10 || counter[12:0] !== 13'd0 || first_ts[43:22] !== 22'd0 || first_seen !== 2'b10) begin
      errors++;
      $display("FAIL mask0_results: cnt1=%0d cnt0=%0d ts1=%0d seen=%b want 10 0 0 10",
               counter[25:13], counter[12:0], first_ts[43:22], first_seen);
    end
    sample(1'b0, 11'h0, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int h = 1; h <= 20; h++) begin
      sample(1'b1, PAT, 1'b0, 1'b0);
      checks++;
      if (counter4[3:0] !== 4'((h < 15) ? h : 15) || saturated4[0] !== (h >= 15) || match4[0] !== 1'b1) begin
        errors++;
        $display("FAIL sat h=%0d: cnt=%0d sat=%b match=%b want %0d %b 1",
                 h, counter4[3:0], saturated4[0], match4[0], (h < 15) ? h : 15, h >= 15);
      end
    end
    checks++;
    if (counter[12:0] !== 13'd20 || saturated[0] !== 1'b0) begin
      errors++;
      $display("FAIL wide_nosat: cnt0=%0d sat0=%b want 20 0", counter[12:0], saturated[0]);
    end
    sample(1'b0, 11'h0, 1'b0, 1'b1);
  endtask

  task automatic test_loop_stop();
    pulse_start();
    for (int k = 0; k < 7; k++) sample(1'b1, 11'h000, 1'b0, 1'b0);
    sample(1'b1, PAT, 1'b1, 1'b0);
    checks++;
    if (counter[12:0] !== 13'd1 || first_ts[21:0] !== 22'd7 || match[0] !== 1'b1 || {busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL loop_hit: cnt0=%0d ts0=%0d match0=%b busy=%b done=%b want 1 7 1 0 1",
               counter[12:0], first_ts[21:0], match[0], busy, done);
    end
    checks++;
    if (counter[25:13] !== 13'd8 || first_ts[43:22] !== 22'd0) begin
      errors++;
      $display("FAIL loop_ch1: cnt1=%0d ts1=%0d want 8 0", counter[25:13], first_ts[43:22]);
    end
    sample(1'b1, PAT, 1'b0, 1'b0);
    checks++;
    if (counter[12:0] !== 13'd1 || match !== 2'b00) begin
      errors++;
      $display("FAIL after_done: cnt0=%0d match=%b want 1 00", counter[12:0], match);
    end
    pulse_start();
    sample(1'b1, PAT, 1'b1, 1'b1);
    checks++;
    if (counter !== '0 || match !== 2'b00 || first_seen !== 2'b00 || done !== 1'b1) begin
      errors++;
      $display("FAIL stop_priority: cnt=%h match=%b seen=%b done=%b want 0 00 00 1", counter, match, first_seen, done);
    end
  endtask

  task automatic test_cfg_and_reset();
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_pattern = 11'h001; cfg_mask = 11'h7FF;
    start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    sample(1'b1, 11'h001, 1'b0, 1'b0);
    checks++;
    if (match[0] !== 1'b1 || counter[12:0] !== 13'd1) begin
      errors++;
      $display("FAIL cfg_with_start: match0=%b cnt0=%0d want 1 1", match[0], counter[12:0]);
    end
    cfg_we = 1'b1; cfg_pattern = 11'h7FF;
    sample(1'b1, 11'h001, 1'b0, 1'b0);
    cfg_we = 1'b0;
    sample(1'b1, 11'h7FF, 1'b0, 1'b0);
    checks++;
    if (counter[12:0] !== 13'd2 || match[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_in_run: cnt0=%0d match0=%b want 2 0", counter[12:0], match[0]);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, match, saturated, first_seen} !== 8'h00 || counter !== '0 || first_ts !== '0 ||
        u_dut.g_ch[0].u_ch.pat_q !== 11'h6AC || u_dut.g_ch[1].u_ch.mask_q !== 11'h7FF) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b cnt=%h seen=%b pat0=%h mask1=%h want 0 0 00 6ac 7ff",
               busy, counter, first_seen, u_dut.g_ch[0].u_ch.pat_q, u_dut.g_ch[1].u_ch.mask_q);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_mask_zero();
    test_saturation();
    test_loop_stop();
    test_cfg_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
